// File: rtl/reg_cntr_pkg.sv
// Shared definitions for the time-of-day counter bank: register field codes,
// CONTROL/STATUS bit positions and the snapshot trigger bit.
package reg_cntr_pkg;

    typedef enum logic [1:0] {
        FIELD_COUNT   = 2'd0,
        FIELD_COMPARE = 2'd1,
        FIELD_CONTROL = 2'd2,
        FIELD_STATUS  = 2'd3
    } field_e;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_SATURATE = 1;
    localparam int CTRL_RELOAD   = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_BITS     = 4;

    localparam int STAT_MATCH    = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_BITS     = 2;

    localparam int SNAPSHOT_BIT  = 31;

    // Counters narrower than 32 bits use their top bit as the snapshot trigger.
    function automatic int snapshotBit(input int width);
        return (width > SNAPSHOT_BIT) ? SNAPSHOT_BIT : width - 1;
    endfunction

endpackage

// File: rtl/reg_cntr_chan.sv
// One counter channel: count, compare, control, sticky status and, when
// CNTR_BANK_SNAPSHOT_EN is defined, a shadow copy of the count for coherent reads.
module reg_cntr_chan
    import reg_cntr_pkg::*;
#(
    parameter int P_WIDTH = 32
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               tick_i,
    input  logic               wr_count_i,
    input  logic               wr_compare_i,
    input  logic               wr_control_i,
    input  logic               wr_status_i,
    input  logic [P_WIDTH-1:0] wdata_i,
`ifdef CNTR_BANK_SNAPSHOT_EN
    input  logic               snapshot_i,
`endif
    output logic [P_WIDTH-1:0] count_o,
    output logic [P_WIDTH-1:0] compare_o,
    output logic [P_WIDTH-1:0] control_o,
    output logic [P_WIDTH-1:0] status_o,
    output logic               match_o,
    output logic               irq_o
);

    logic [P_WIDTH-1:0]   count_q, count_d, compare_q, nextCount;
    logic [CTRL_BITS-1:0] control_q, wdataCtrl;
    logic [STAT_BITS-1:0] status_q, status_d, statusSet, statusClr, wdataStat;

    assign wdataCtrl = CTRL_BITS'(wdata_i);
    assign wdataStat = STAT_BITS'(wdata_i);

    // A COUNT write swallows a coincident tick; status sets beat a same-cycle clear.
    always_comb begin
        count_d   = count_q;
        nextCount = count_q;
        statusSet = '0;
        if (wr_count_i) begin
            count_d = wdata_i;
        end else if (tick_i && control_q[CTRL_ENABLE]) begin
            if (count_q == '1) begin
                statusSet[STAT_OVERFLOW] = 1'b1;
                nextCount = control_q[CTRL_SATURATE] ? '1 : '0;
            end else begin
                nextCount = count_q + P_WIDTH'(1);
            end
            if (nextCount == compare_q) begin
                statusSet[STAT_MATCH] = 1'b1;
                count_d = control_q[CTRL_RELOAD] ? '0 : nextCount;
            end else begin
                count_d = nextCount;
            end
        end
        statusClr = wr_status_i ? wdataStat : '0;
        status_d  = (status_q & ~statusClr) | statusSet;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q   <= '0;
            compare_q <= '0;
            control_q <= '0;
            status_q  <= '0;
        end else begin
            count_q  <= count_d;
            status_q <= status_d;
            if (wr_compare_i) compare_q <= wdata_i;
            if (wr_control_i) control_q <= wdataCtrl;
        end
    end

`ifdef CNTR_BANK_SNAPSHOT_EN
    logic [P_WIDTH-1:0] shadow_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_q <= '0;
        end else if (snapshot_i) begin
            shadow_q <= count_q;
        end
    end

    assign count_o = shadow_q;
`else
    assign count_o = count_q;
`endif

    assign compare_o = compare_q;
    assign control_o = P_WIDTH'(control_q);
    assign status_o  = P_WIDTH'(status_q);
    assign match_o   = status_q[STAT_MATCH];
    assign irq_o     = status_q[STAT_MATCH] & control_q[CTRL_IRQ_EN];

endmodule

// File: rtl/reg_tod_cntr_bank.sv
// Register-mapped bank of time-of-day counters sharing one prescaled tick.
// Define CNTR_BANK_SNAPSHOT_EN to add per-channel snapshot shadows for coherent COUNT reads.
module reg_tod_cntr_bank
    import reg_cntr_pkg::*;
#(
    parameter int P_WIDTH    = 32,
    parameter int P_CHANNELS = 4,
    parameter int P_PRESCALE = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  INCREMENT,
    input  logic [P_CHANNELS-1:0] REG_SELECT,
    input  logic [1:0]            REG_FIELD,
    input  logic                  REG_WRITE,
    input  logic                  REG_READ,
    input  logic [P_WIDTH-1:0]    DATA_IN,
    output logic [P_WIDTH-1:0]    DATA_OUT_Q,
    output logic [P_CHANNELS-1:0] MATCH_Q,
    output logic                  IRQ_Q
);

    localparam logic [15:0] PRESC_LAST = 16'(P_PRESCALE - 1);

    logic [15:0]           presc_q, presc_d;
    logic                  tick_q, tick_d;
    field_e                regField;
    logic                  selOneHot;
    logic [P_WIDTH-1:0]    readData;
    logic [P_CHANNELS-1:0] chanIrq;
    logic [P_WIDTH-1:0]    chanCount   [P_CHANNELS];
    logic [P_WIDTH-1:0]    chanCompare [P_CHANNELS];
    logic [P_WIDTH-1:0]    chanControl [P_CHANNELS];
    logic [P_WIDTH-1:0]    chanStatus  [P_CHANNELS];

    assign regField  = field_e'(REG_FIELD);
    assign selOneHot = (REG_SELECT != '0) &&
                       ((REG_SELECT & (REG_SELECT - P_CHANNELS'(1))) == '0);

`ifdef CNTR_BANK_SNAPSHOT_EN
    localparam int SNAP_IDX = snapshotBit(P_WIDTH);
    logic snapshot;
    assign snapshot = REG_WRITE && (regField == FIELD_STATUS) &&
                      (|REG_SELECT) && DATA_IN[SNAP_IDX];
`endif

    // The tick is registered, so counts move one cycle after the qualifying pulse.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (INCREMENT) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < P_CHANNELS; i++) begin : g_chan
        reg_cntr_chan #(.P_WIDTH(P_WIDTH)) u_chan (
            .CLOCK        (CLOCK),
            .RESET_N      (RESET_N),
            .tick_i       (tick_q),
            .wr_count_i   (REG_WRITE && REG_SELECT[i] && (regField == FIELD_COUNT)),
            .wr_compare_i (REG_WRITE && REG_SELECT[i] && (regField == FIELD_COMPARE)),
            .wr_control_i (REG_WRITE && REG_SELECT[i] && (regField == FIELD_CONTROL)),
            .wr_status_i  (REG_WRITE && REG_SELECT[i] && (regField == FIELD_STATUS)),
            .wdata_i      (DATA_IN),
`ifdef CNTR_BANK_SNAPSHOT_EN
            .snapshot_i   (snapshot),
`endif
            .count_o      (chanCount[i]),
            .compare_o    (chanCompare[i]),
            .control_o    (chanControl[i]),
            .status_o     (chanStatus[i]),
            .match_o      (MATCH_Q[i]),
            .irq_o        (chanIrq[i])
        );
    end

    // Zero or multi-hot selects read as 0 rather than an OR of channels.
    always_comb begin
        readData = '0;
        for (int i = 0; i < P_CHANNELS; i++) begin
            if (REG_SELECT[i]) begin
                case (regField)
                    FIELD_COUNT:   readData = readData | chanCount[i];
                    FIELD_COMPARE: readData = readData | chanCompare[i];
                    FIELD_CONTROL: readData = readData | chanControl[i];
                    FIELD_STATUS:  readData = readData | chanStatus[i];
                    default:       readData = readData;
                endcase
            end
        end
        if (!selOneHot) readData = '0;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            DATA_OUT_Q <= '0;
            IRQ_Q      <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            IRQ_Q   <= |chanIrq;
            if (REG_READ) DATA_OUT_Q <= readData;
        end
    end

endmodule

// File: tb/tb_reg_tod_cntr_bank.sv
// Directed scoreboard bench for reg_tod_cntr_bank (8-bit, 4 channels, prescale 3);
// snapshot expectations follow CNTR_BANK_SNAPSHOT_EN.
module tb_reg_tod_cntr_bank;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int PS = 3;

    localparam logic [1:0] F_COUNT   = 2'd0;
    localparam logic [1:0] F_COMPARE = 2'd1;
    localparam logic [1:0] F_CONTROL = 2'd2;
    localparam logic [1:0] F_STATUS  = 2'd3;

    localparam logic [N-1:0] CH0 = 4'b0001;
    localparam logic [N-1:0] CH1 = 4'b0010;
    localparam logic [N-1:0] CH2 = 4'b0100;
    localparam logic [N-1:0] CH3 = 4'b1000;

    logic         CLOCK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         INCREMENT = 1'b0;
    logic [N-1:0] REG_SELECT = '0;
    logic [1:0]   REG_FIELD = '0;
    logic         REG_WRITE = 1'b0;
    logic         REG_READ = 1'b0;
    logic [W-1:0] DATA_IN = '0;
    logic [W-1:0] DATA_OUT_Q;
    logic [N-1:0] MATCH_Q;
    logic         IRQ_Q;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] expQ[$];
    string        tagQ[$];
    logic [W-1:0] snapExp0, snapExp1;

    reg_tod_cntr_bank #(.P_WIDTH(W), .P_CHANNELS(N), .P_PRESCALE(PS)) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .INCREMENT  (INCREMENT),
        .REG_SELECT (REG_SELECT),
        .REG_FIELD  (REG_FIELD),
        .REG_WRITE  (REG_WRITE),
        .REG_READ   (REG_READ),
        .DATA_IN    (DATA_IN),
        .DATA_OUT_Q (DATA_OUT_Q),
        .MATCH_Q    (MATCH_Q),
        .IRQ_Q      (IRQ_Q)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; inputs change 1ns after the edge and are released afterwards.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [N-1:0] sel,
                                 input logic [1:0] fld, input logic [W-1:0] data, input logic inc);
        REG_WRITE  = wr;
        REG_READ   = rd;
        REG_SELECT = sel;
        REG_FIELD  = fld;
        DATA_IN    = data;
        INCREMENT  = inc;
        @(posedge CLOCK);
        #1;
        REG_WRITE  = 1'b0;
        REG_READ   = 1'b0;
        REG_SELECT = '0;
        REG_FIELD  = '0;
        DATA_IN    = '0;
        INCREMENT  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, 1'b0);
    endtask

    task automatic writeReg(input logic [N-1:0] sel, input logic [1:0] fld, input logic [W-1:0] data);
        applyStimulus(1'b1, 1'b0, sel, fld, data, 1'b0);
    endtask

    task automatic pulses(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, 1'b1);
        idle(1);
    endtask

    task automatic checkOutput();
        string tag;
        logic [W-1:0] expected;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: observed=0x%0h expected=none queued", DATA_OUT_Q);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            checkValue(tag, 32'(DATA_OUT_Q), 32'(expected));
        end
    endtask

    task automatic readReg(input logic [N-1:0] sel, input logic [1:0] fld,
                           input logic [W-1:0] expected, input string tag);
        expQ.push_back(expected);
        tagQ.push_back(tag);
        applyStimulus(1'b0, 1'b1, sel, fld, '0, 1'b0);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge CLOCK);
        #1;
        checkValue("resetDataOut", 32'(DATA_OUT_Q), 32'h0);
        checkValue("resetMatch", 32'(MATCH_Q), 32'h0);
        checkValue("resetIrq", 32'(IRQ_Q), 32'h0);
        RESET_N = 1'b1;
        idle(1);
        readReg(CH0, F_COUNT, 8'h00, "resetCount");

        // Prescale by 3: nine pulses give three ticks.
        writeReg(CH0, F_CONTROL, 8'h01);
        pulses(9);
        readReg(CH0, F_COUNT, 8'h03, "prescaleCount");
        readReg(CH1, F_COUNT, 8'h00, "disabledCount");
        writeReg(CH2, F_CONTROL, 8'hF2);
        readReg(CH2, F_CONTROL, 8'h02, "controlMask");

        // Compare match with auto-reload and interrupt.
        writeReg(CH0, F_COUNT, 8'h00);
        writeReg(CH0, F_COMPARE, 8'h05);
        writeReg(CH0, F_CONTROL, 8'h0D);
        pulses(15);
        checkValue("matchFlag", 32'(MATCH_Q), 32'h1);
        checkValue("irqLag", 32'(IRQ_Q), 32'h0);
        idle(1);
        checkValue("irqSet", 32'(IRQ_Q), 32'h1);
        readReg(CH0, F_COUNT, 8'h00, "reloadCount");
        readReg(CH0, F_STATUS, 8'h01, "matchStatus");
        writeReg(CH0, F_STATUS, 8'h01);
        checkValue("matchCleared", 32'(MATCH_Q), 32'h0);
        idle(1);
        checkValue("irqCleared", 32'(IRQ_Q), 32'h0);

        // Wrap and saturate at all-ones.
        writeReg(CH0, F_CONTROL, 8'h01);
        writeReg(CH0, F_COUNT, 8'hFF);
        pulses(3);
        readReg(CH0, F_COUNT, 8'h00, "wrapCount");
        readReg(CH0, F_STATUS, 8'h02, "wrapOverflow");
        writeReg(CH0, F_STATUS, 8'h02);
        writeReg(CH0, F_CONTROL, 8'h03);
        writeReg(CH0, F_COUNT, 8'hFF);
        pulses(3);
        readReg(CH0, F_COUNT, 8'hFF, "satCount");
        readReg(CH0, F_STATUS, 8'h02, "satOverflow");
        writeReg(CH0, F_STATUS, 8'h03);
        readReg(CH0, F_STATUS, 8'h00, "statusW1C");

        // COUNT write on the tick cycle wins and the tick is lost.
        writeReg(CH0, F_CONTROL, 8'h01);
        writeReg(CH0, F_COUNT, 8'h20);
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, 1'b1);
        writeReg(CH0, F_COUNT, 8'h10);
        idle(1);
        readReg(CH0, F_COUNT, 8'h10, "writeBeatsTick");

        // Match set and W1C in the same cycle: the set wins.
        writeReg(CH1, F_COMPARE, 8'h01);
        writeReg(CH1, F_COUNT, 8'h00);
        writeReg(CH1, F_CONTROL, 8'h01);
        repeat (3) applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, 1'b1);
        writeReg(CH1, F_STATUS, 8'h01);
        checkValue("setBeatsClear", 32'(MATCH_Q), 32'h2);
        readReg(CH1, F_STATUS, 8'h01, "setBeatsClearStatus");
        readReg(CH1, F_COUNT, 8'h01, "matchNoReload");
        checkValue("irqMasked", 32'(IRQ_Q), 32'h0);

        // Multi-select writes, non-one-hot reads, read hold and read-during-write.
        writeReg(CH2 | CH3, F_COMPARE, 8'h42);
        readReg(CH2, F_COMPARE, 8'h42, "multiWrite2");
        readReg(CH3, F_COMPARE, 8'h42, "multiWrite3");
        idle(1);
        checkValue("readHold", 32'(DATA_OUT_Q), 32'h42);
        readReg(CH2 | CH3, F_COMPARE, 8'h00, "multiHotRead");
        readReg(4'b0000, F_COMPARE, 8'h00, "zeroSelRead");
        expQ.push_back(8'h42);
        tagQ.push_back("readBeforeWrite");
        applyStimulus(1'b1, 1'b1, CH2, F_COMPARE, 8'h55, 1'b0);
        checkOutput();
        readReg(CH2, F_COMPARE, 8'h55, "readAfterWrite");

        // Snapshot ch0=7 and ch1=9, then four more ticks.
        writeReg(CH0, F_COUNT, 8'h07);
        writeReg(CH1, F_COUNT, 8'h09);
        writeReg(CH0, F_STATUS, 8'h80);
        pulses(12);
`ifdef CNTR_BANK_SNAPSHOT_EN
        snapExp0 = 8'h07;
        snapExp1 = 8'h09;
`else
        snapExp0 = 8'h0B;
        snapExp1 = 8'h0D;
`endif
        readReg(CH0, F_COUNT, snapExp0, "snapCh0");
        readReg(CH1, F_COUNT, snapExp1, "snapCh1");
        writeReg(CH2, F_STATUS, 8'h80);
        readReg(CH0, F_COUNT, 8'h0B, "resnapCh0");
        readReg(CH1, F_COUNT, 8'h0D, "resnapCh1");

        // Asynchronous reset mid-prescale with live state everywhere.
        writeReg(CH1, F_CONTROL, 8'h09);
        idle(1);
        checkValue("preResetIrq", 32'(IRQ_Q), 32'h1);
        applyStimulus(1'b0, 1'b0, '0, 2'd0, '0, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        checkValue("asyncDataOut", 32'(DATA_OUT_Q), 32'h0);
        checkValue("asyncMatch", 32'(MATCH_Q), 32'h0);
        checkValue("asyncIrq", 32'(IRQ_Q), 32'h0);
        @(posedge CLOCK);
        #1;
        RESET_N = 1'b1;
        idle(1);
        writeReg(CH0, F_CONTROL, 8'h01);
        pulses(2);
        readReg(CH0, F_COUNT, 8'h00, "prescaleRestart");
        pulses(1);
        readReg(CH0, F_COUNT, 8'h01, "firstTickAfterReset");
        readReg(CH1, F_CONTROL, 8'h00, "controlReset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_tod_cntr_bank.md
# reg_tod_cntr_bank

Multi-channel, register-mapped time-of-day counter bank for the power sequencer's timing and housekeeping logic. It replaces the single loadable counter with P_CHANNELS independent counters. The counters share a prescaled tick and each has a compare/match flag, wrap or saturate mode, sticky status and an interrupt output. An optional snapshot mechanism gives coherent multi-channel reads.

## Interface
- P_WIDTH, 32, counter and compare width (2..64)
- P_CHANNELS, 4, number of counter channels (1..16)
- P_PRESCALE, 1, INCREMENT pulses per counter tick (1..65535; 1 = no prescale)
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  reset, asynchronous, active-low
- INCREMENT  in  1  global time-base pulse, one CLOCK wide
- REG_SELECT  in  P_CHANNELS  one-hot channel select
- REG_FIELD  in  2  0=COUNT, 1=COMPARE, 2=CONTROL, 3=STATUS
- REG_WRITE  in  1  write strobe
- REG_READ  in  1  read strobe
- DATA_IN  in  P_WIDTH  write data
- DATA_OUT_Q  out  P_WIDTH  registered read data
- MATCH_Q  out  P_CHANNELS  per-channel sticky match flag (copy of STATUS bit0)
- IRQ_Q  out  1  registered OR over channels of (match & irq_en)

## Operation
- Prescaler: shared counter over INCREMENT pulses. Tick = INCREMENT pulse on which prescaler == P_PRESCALE-1; prescaler then returns to 0. P_PRESCALE=1: tick = INCREMENT.
- CONTROL bits: [0] enable, [1] saturate (0 = wrap), [2] auto-reload-on-match, [3] irq_en. Other bits are ignored on write and read as 0.
- STATUS bits: [0] match, [1] overflow, both sticky and write-1-to-clear. Other bits read 0.
- Per channel, priority order, highest first:
  - COUNT write: loads DATA_IN. The tick is lost that cycle. No match or overflow is set.
  - Tick while enabled:
    - next = count+1.
    - At all-ones: wrap mode gives 0; saturate mode holds all-ones. Overflow sets in both modes.
    - If next == compare: match sets; count becomes 0 if auto-reload, else next.
  - Otherwise hold.
- Status set and W1C in the same cycle: set wins.
- Writes with several REG_SELECT bits set go to every selected channel.
- Reads:
  - One-hot select: DATA_OUT_Q gets the field value.
  - Zero or multi-hot select: DATA_OUT_Q gets 0.
  - DATA_OUT_Q holds when REG_READ is low.
- REG_READ and REG_WRITE in the same cycle: the read returns the pre-write value.
- Reset: all counts, compares, control, status, prescaler, DATA_OUT_Q, MATCH_Q and IRQ_Q are 0. Reset mid-count discards all state, and the prescaler restarts.

## Timing
- Write takes effect in the register on the CLOCK edge sampling REG_WRITE.
- Tick to count update: 1 cycle after the edge sampling the qualifying INCREMENT.
- Read latency: DATA_OUT_Q is valid 1 cycle after REG_READ is sampled.
- MATCH_Q: same cycle as the STATUS register.
- IRQ_Q: 1 cycle after MATCH_Q.
- No back-pressure. Accesses may occur on every cycle.

## Configuration
- CNTR_BANK_SNAPSHOT_EN defined:
  - Writing STATUS with DATA_IN[31] (bit P_WIDTH-1 if narrower) set, any channel selected, copies every channel's count into a per-channel shadow in one cycle.
  - COUNT reads return the shadow.
  - Shadows reset to 0.
- Not defined: no shadow registers. COUNT reads return the live count and the snapshot bit is ignored.

## Structure
- Package reg_cntr_pkg holds:
  - field enum (COUNT/COMPARE/CONTROL/STATUS)
  - CONTROL and STATUS bit-position constants
  - snapshot bit index
- Sub-module reg_cntr_chan: one channel's count, compare, control, status and optional shadow. It takes tick, write decode and snapshot inputs and returns field read values.
- Top level holds the prescaler, select decode, read mux, DATA_OUT_Q, IRQ reduction and a generate loop over the channels.

## Test plan
- P_PRESCALE=3, ch0 enabled, 9 INCREMENT pulses → ch0 COUNT reads 3. Ch1 (disabled) reads 0.
- Ch0 compare=5, auto-reload, 5 ticks → count 0, MATCH_Q[0]=1, IRQ_Q=1 one cycle later. STATUS W1C 0x1 → MATCH_Q[0]=0, IRQ_Q=0.
- P_WIDTH=8:
  - Wrap: count loaded 0xFF, 1 tick → 0x00, overflow=1.
  - Saturate: same stimulus → 0xFF, overflow=1.
- COUNT write 0x10 coincident with tick → 0x10. Match set coincident with W1C → match stays 1.
- Reset asserted mid-prescale with counts non-zero → every output 0 immediately. The next count increment needs P_PRESCALE fresh pulses after release.
- CNTR_BANK_SNAPSHOT_EN: snapshot with ch0=7 and ch1=9, then 4 more ticks → reads return 7/9 until the next snapshot. Without the macro the reads return live values.
